// File: rtl/ram_datapath_seq_if.sv
// Request channel from the decode stage into the datapath sequencer.
interface ram_datapath_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rn;
  logic [4:0]  req_rm;
  logic [4:0]  req_fs;
  logic        req_c0;
  logic [63:0] req_imm;

  modport master (
    output req_valid, req_op, req_rd, req_rn, req_rm, req_fs, req_c0, req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rn, req_rm, req_fs, req_c0, req_imm,
    output req_ready
  );
endinterface

// File: rtl/ram_datapath_seq.sv
// Multi-cycle control sequencer for the register-file/ALU/RAM datapath.
// All outputs are registered and decoded from the next state plus the
// latched request, so they are a clean Moore function of the current state.
module ram_datapath_seq (
  input  logic                 clk,
  input  logic                 rst,
  ram_datapath_seq_if.slave    req,
  output logic                 W,
  output logic                 EN_B,
  output logic                 EN_ALU,
  output logic                 EN_ADDR,
  output logic                 K_SEL,
  output logic                 PC_SEL,
  output logic                 C0,
  output logic                 CS,
  output logic                 WE,
  output logic                 OE,
  output logic [4:0]           SA,
  output logic [4:0]           SB,
  output logic [4:0]           DA,
  output logic [4:0]           FS,
  output logic [63:0]          K,
  output logic [63:0]          CU,
  output logic                 pc_load,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          retired
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 32;

  localparam logic [REG_W-1:0] FS_ADD    = 5'b01000;
  localparam logic [OP_W-1:0]  OP_ALU_R  = 3'd0;
  localparam logic [OP_W-1:0]  OP_ALU_I  = 3'd1;
  localparam logic [OP_W-1:0]  OP_LOAD   = 3'd2;
  localparam logic [OP_W-1:0]  OP_STORE  = 3'd3;
  localparam logic [OP_W-1:0]  OP_BR_REG = 3'd4;
  localparam logic [OP_W-1:0]  OP_BR_IMM = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_LD_ADDR, S_LD_WB, S_ST_SETUP, S_ST_WR
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     f_op_q, f_op_d;
  logic [REG_W-1:0]    f_rd_q, f_rd_d, f_rn_q, f_rn_d, f_rm_q, f_rm_d, f_fs_q, f_fs_d;
  logic                f_c0_q, f_c0_d;
  logic [DATA_W-1:0]   f_imm_q, f_imm_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic w_q, w_d, en_b_q, en_b_d, en_alu_q, en_alu_d, en_addr_q, en_addr_d;
  logic k_sel_q, k_sel_d, pc_sel_q, pc_sel_d, c0_q, c0_d;
  logic cs_q, cs_d, we_q, we_d, oe_q, oe_d;
  logic pc_load_q, pc_load_d, done_q, done_d, err_q, err_d, ready_q, ready_d;
  logic [REG_W-1:0]  sa_q, sa_d, sb_q, sb_d, da_q, da_d, fs_q, fs_d;
  logic [DATA_W-1:0] k_q, k_d, cu_q, cu_d;

  // Next state, request capture and decode of the next cycle's control word.
  always_comb begin
    state_d   = state_q;
    f_op_d    = f_op_q;
    f_rd_d    = f_rd_q;
    f_rn_d    = f_rn_q;
    f_rm_d    = f_rm_q;
    f_fs_d    = f_fs_q;
    f_c0_d    = f_c0_q;
    f_imm_d   = f_imm_q;
    retired_d = retired_q + CNT_W'(done_q);

    case (state_q)
      S_IDLE: begin
        if (req.req_valid) begin
          f_op_d  = req.req_op;
          f_rd_d  = req.req_rd;
          f_rn_d  = req.req_rn;
          f_rm_d  = req.req_rm;
          f_fs_d  = req.req_fs;
          f_c0_d  = req.req_c0;
          f_imm_d = req.req_imm;
          case (req.req_op)
            OP_LOAD:  state_d = S_LD_ADDR;
            OP_STORE: state_d = S_ST_SETUP;
            default:  state_d = S_EXEC;
          endcase
        end
      end
      S_LD_ADDR:  state_d = S_LD_WB;
      S_ST_SETUP: state_d = S_ST_WR;
      default:    state_d = S_IDLE;
    endcase

    w_d = 1'b0;  en_b_d = 1'b0;  en_alu_d = 1'b0;  en_addr_d = 1'b0;
    k_sel_d = 1'b0;  pc_sel_d = 1'b0;  c0_d = 1'b0;
    cs_d = 1'b0;  we_d = 1'b0;  oe_d = 1'b0;
    pc_load_d = 1'b0;  done_d = 1'b0;  err_d = 1'b0;
    sa_d = '0;  sb_d = '0;  da_d = '0;  fs_d = '0;
    k_d = '0;  cu_d = '0;
    ready_d = (state_d == S_IDLE);

    case (state_d)
      S_EXEC: begin
        done_d = 1'b1;
        case (f_op_d)
          OP_ALU_R, OP_ALU_I: begin
            sa_d     = f_rn_d;
            sb_d     = f_rm_d;
            fs_d     = f_fs_d;
            c0_d     = f_c0_d;
            en_alu_d = 1'b1;
            w_d      = 1'b1;
            da_d     = f_rd_d;
            if (f_op_d == OP_ALU_I) begin
              k_sel_d = 1'b1;
              k_d     = f_imm_d;
            end
          end
          OP_BR_REG: begin
            sa_d      = f_rn_d;
            pc_sel_d  = 1'b1;
            pc_load_d = 1'b1;
          end
          OP_BR_IMM: begin
            cu_d      = f_imm_d;
            pc_load_d = 1'b1;
          end
          default: err_d = 1'b1;
        endcase
      end
      S_LD_ADDR, S_LD_WB, S_ST_SETUP, S_ST_WR: begin
        // Address = R[rn] + imm through the ALU, steered onto the address bus.
        sa_d      = f_rn_d;
        k_sel_d   = 1'b1;
        k_d       = f_imm_d;
        fs_d      = FS_ADD;
        en_addr_d = 1'b1;
        if (state_d == S_LD_ADDR || state_d == S_LD_WB) begin
          cs_d = 1'b1;
          oe_d = 1'b1;
          if (state_d == S_LD_WB) begin
            w_d    = 1'b1;
            da_d   = f_rd_d;
            done_d = 1'b1;
          end
        end else begin
          sb_d   = f_rd_d;
          en_b_d = 1'b1;
          if (state_d == S_ST_WR) begin
            cs_d   = 1'b1;
            we_d   = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State, latched request, counter and registered control word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      f_op_q <= '0;  f_rd_q <= '0;  f_rn_q <= '0;  f_rm_q <= '0;
      f_fs_q <= '0;  f_c0_q <= 1'b0;  f_imm_q <= '0;
      retired_q <= '0;
      w_q <= 1'b0;  en_b_q <= 1'b0;  en_alu_q <= 1'b0;  en_addr_q <= 1'b0;
      k_sel_q <= 1'b0;  pc_sel_q <= 1'b0;  c0_q <= 1'b0;
      cs_q <= 1'b0;  we_q <= 1'b0;  oe_q <= 1'b0;
      pc_load_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;  ready_q <= 1'b1;
      sa_q <= '0;  sb_q <= '0;  da_q <= '0;  fs_q <= '0;
      k_q <= '0;  cu_q <= '0;
    end else begin
      state_q <= state_d;
      f_op_q <= f_op_d;  f_rd_q <= f_rd_d;  f_rn_q <= f_rn_d;  f_rm_q <= f_rm_d;
      f_fs_q <= f_fs_d;  f_c0_q <= f_c0_d;  f_imm_q <= f_imm_d;
      retired_q <= retired_d;
      w_q <= w_d;  en_b_q <= en_b_d;  en_alu_q <= en_alu_d;  en_addr_q <= en_addr_d;
      k_sel_q <= k_sel_d;  pc_sel_q <= pc_sel_d;  c0_q <= c0_d;
      cs_q <= cs_d;  we_q <= we_d;  oe_q <= oe_d;
      pc_load_q <= pc_load_d;  done_q <= done_d;  err_q <= err_d;  ready_q <= ready_d;
      sa_q <= sa_d;  sb_q <= sb_d;  da_q <= da_d;  fs_q <= fs_d;
      k_q <= k_d;  cu_q <= cu_d;
    end
  end

  assign req.req_ready = ready_q;
  assign W       = w_q;
  assign EN_B    = en_b_q;
  assign EN_ALU  = en_alu_q;
  assign EN_ADDR = en_addr_q;
  assign K_SEL   = k_sel_q;
  assign PC_SEL  = pc_sel_q;
  assign C0      = c0_q;
  assign CS      = cs_q;
  assign WE      = we_q;
  assign OE      = oe_q;
  assign SA      = sa_q;
  assign SB      = sb_q;
  assign DA      = da_q;
  assign FS      = fs_q;
  assign K       = k_q;
  assign CU      = cu_q;
  assign pc_load = pc_load_q;
  assign done    = done_q;
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_ram_datapath_seq.sv
// Bench for ram_datapath_seq: a behavioural datapath (register file, adder,
// RAM) is driven by the DUT's control word, and every cycle's control word is
// compared with one derived from the operation's rules.
module tb_ram_datapath_seq;

  localparam logic [4:0] FS_ADD    = 5'b01000;
  localparam logic [2:0] OP_ALU_R  = 3'd0;
  localparam logic [2:0] OP_ALU_I  = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_BR_REG = 3'd4;
  localparam logic [2:0] OP_BR_IMM = 3'd5;

  typedef struct packed {
    logic w, en_b, en_alu, en_addr, k_sel, pc_sel, c0, cs, we, oe, pc_load, done, err;
    logic [4:0] sa, sb, da, fs;
    logic [63:0] k, cu;
  } ctrl_t;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] rd, rn, rm, fs;
    logic c0;
    logic [63:0] imm;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic W, EN_B, EN_ALU, EN_ADDR, K_SEL, PC_SEL, C0, CS, WE, OE, pc_load, done, err;
  logic [4:0] SA, SB, DA, FS;
  logic [63:0] K, CU;
  logic [31:0] retired;

  ram_datapath_seq_if rif ();

  ram_datapath_seq dut (
    .clk(clk), .rst(rst), .req(rif),
    .W(W), .EN_B(EN_B), .EN_ALU(EN_ALU), .EN_ADDR(EN_ADDR), .K_SEL(K_SEL),
    .PC_SEL(PC_SEL), .C0(C0), .CS(CS), .WE(WE), .OE(OE),
    .SA(SA), .SB(SB), .DA(DA), .FS(FS), .K(K), .CU(CU),
    .pc_load(pc_load), .done(done), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  logic [31:0] exp_retired = 32'd0;
  ctrl_t act;
  logic [63:0] rf [32];
  logic [63:0] ram [256];

  always_comb begin
    act = '0;
    act.w = W;  act.en_b = EN_B;  act.en_alu = EN_ALU;  act.en_addr = EN_ADDR;
    act.k_sel = K_SEL;  act.pc_sel = PC_SEL;  act.c0 = C0;
    act.cs = CS;  act.we = WE;  act.oe = OE;
    act.pc_load = pc_load;  act.done = done;  act.err = err;
    act.sa = SA;  act.sb = SB;  act.da = DA;  act.fs = FS;
    act.k = K;  act.cu = CU;
  end

  // Behavioural datapath: only the adder function is modelled.
  function automatic logic [63:0] alu_out();
    logic [63:0] b;
    b = act.k_sel ? act.k : rf[act.sb];
    return (act.fs == FS_ADD) ? rf[act.sa] + b + 64'(act.c0) : 64'h0;
  endfunction

  function automatic logic [7:0] ram_addr();
    logic [63:0] a;
    a = alu_out();
    return a[7:0];
  endfunction

  function automatic logic [63:0] bus_val();
    if (act.en_alu) return alu_out();
    if (act.en_b) return rf[act.sb];
    if (act.cs && act.oe) return ram[ram_addr()];
    return 64'h0;
  endfunction

  always @(posedge clk) if (act.w) rf[act.da] = bus_val();
  always @(negedge clk) if (act.cs && act.we) ram[ram_addr()] = bus_val();

  // Bus-ownership invariants, every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      tot++;
      if ((act.en_b && act.en_alu) || (act.oe && (act.en_b || act.en_alu)) ||
          (act.we && !act.cs) || (act.w && act.we)) begin
        bad++;
        $display("FAIL bus_invariant t=%0t en_b=%b en_alu=%b oe=%b cs=%b we=%b w=%b",
                 $time, act.en_b, act.en_alu, act.oe, act.cs, act.we, act.w);
      end
    end
  end

  function automatic int n_cycles(input logic [2:0] op);
    return (op == OP_LOAD || op == OP_STORE) ? 2 : 1;
  endfunction

  // Control word expected in cycle ph (0-based) after an op is accepted.
  function automatic ctrl_t exp_ctrl(input req_t r, input int ph);
    ctrl_t c;
    logic last;
    c = '0;
    last = (ph == n_cycles(r.op) - 1);
    if (r.op == OP_LOAD || r.op == OP_STORE) begin
      c.sa = r.rn;  c.k_sel = 1'b1;  c.k = r.imm;  c.fs = FS_ADD;  c.en_addr = 1'b1;
      if (r.op == OP_LOAD) begin
        c.cs = 1'b1;  c.oe = 1'b1;
        if (last) begin c.w = 1'b1;  c.da = r.rd; end
      end else begin
        c.sb = r.rd;  c.en_b = 1'b1;
        if (last) begin c.cs = 1'b1;  c.we = 1'b1; end
      end
    end else if (r.op == OP_ALU_R || r.op == OP_ALU_I) begin
      c.sa = r.rn;  c.sb = r.rm;  c.fs = r.fs;  c.c0 = r.c0;
      c.en_alu = 1'b1;  c.w = 1'b1;  c.da = r.rd;
      if (r.op == OP_ALU_I) begin c.k_sel = 1'b1;  c.k = r.imm; end
    end else if (r.op == OP_BR_REG) begin
      c.sa = r.rn;  c.pc_sel = 1'b1;  c.pc_load = 1'b1;
    end else if (r.op == OP_BR_IMM) begin
      c.cu = r.imm;  c.pc_load = 1'b1;
    end else begin
      c.err = 1'b1;
    end
    c.done = last;
    return c;
  endfunction

  function automatic req_t rand_req(input logic [2:0] op);
    req_t r;
    r.op = op;
    r.rd = 5'($urandom);  r.rn = 5'($urandom);  r.rm = 5'($urandom);
    r.fs = 5'($urandom);  r.c0 = 1'($urandom);
    r.imm = {$urandom, $urandom};
    return r;
  endfunction

  task automatic drive_req(input req_t r, input logic v);
    rif.req_op = r.op;  rif.req_rd = r.rd;  rif.req_rn = r.rn;  rif.req_rm = r.rm;
    rif.req_fs = r.fs;  rif.req_c0 = r.c0;  rif.req_imm = r.imm;
    rif.req_valid = v;
  endtask

  // Issue one op, then scramble the request lines while it runs.
  task automatic run_op(input req_t r);
    ctrl_t e;
    int n;
    n = n_cycles(r.op);
    @(negedge clk);
    tot++;
    if (rif.req_ready !== 1'b1) begin
      bad++;  $display("FAIL ready_before_op op=%0d got=%b want=1", r.op, rif.req_ready);
    end
    drive_req(r, 1'b1);
    @(posedge clk); #1;
    drive_req(rand_req(3'($urandom)), 1'b0);
    for (int ph = 0; ph < n; ph++) begin
      e = exp_ctrl(r, ph);
      tot++;
      if (act !== e) begin
        bad++;  $display("FAIL ctrl op=%0d ph=%0d got=%h want=%h", r.op, ph, act, e);
      end
      tot++;
      if (rif.req_ready !== 1'b0) begin
        bad++;  $display("FAIL ready_busy op=%0d ph=%0d got=%b want=0", r.op, ph, rif.req_ready);
      end
      if (ph < n - 1) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    exp_retired = exp_retired + 32'd1;
    tot++;
    if (retired !== exp_retired) begin
      bad++;  $display("FAIL retired op=%0d got=%h want=%h", r.op, retired, exp_retired);
    end
    tot++;
    if (act !== ctrl_t'(0) || rif.req_ready !== 1'b1) begin
      bad++;  $display("FAIL idle_after op=%0d ctrl=%h ready=%b want ctrl=0 ready=1", r.op, act, rif.req_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    req_t r;
    ctrl_t e;
    rst = 1'b1;
    drive_req(rand_req(OP_ALU_R), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rf[0] = 64'h0;  rf[5] = 64'h5A5A;  exp_retired = 32'd0;
    r = rand_req(OP_LOAD);  r.rd = 5'd5;  r.rn = 5'd0;  r.imm = 64'd8;
    @(negedge clk);
    rst = 1'b0;
    drive_req(r, 1'b1);
    @(posedge clk); #1;
    rif.req_valid = 1'b0;
    rst = 1'b1;
    e = exp_ctrl(r, 0);
    @(negedge clk);
    tot++;
    if (act !== e) begin
      bad++;  $display("FAIL midrst_ld_addr got=%h want=%h", act, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tot++;
    if (act !== ctrl_t'(0) || rif.req_ready !== 1'b1) begin
      bad++;  $display("FAIL midrst_idle ctrl=%h ready=%b want ctrl=0 ready=1", act, rif.req_ready);
    end
    @(posedge clk); #1;
    tot++;
    if (act.w !== 1'b0 || act.done !== 1'b0 || retired !== 32'd0 || rf[5] !== 64'h5A5A) begin
      bad++;  $display("FAIL midrst_no_effect w=%b done=%b retired=%h r5=%h want 0 0 0 5a5a",
                       act.w, act.done, retired, rf[5]);
    end
  endtask

  task automatic test_reset();
    req_t r;
    ctrl_t e;
    r = rand_req(OP_ALU_R);
    r.rd = 5'd3;  r.rn = 5'd1;  r.rm = 5'd2;  r.fs = FS_ADD;  r.c0 = 1'b0;
    rf[1] = 64'd5;  rf[2] = 64'd7;  rf[3] = 64'd0;
    rst = 1'b1;
    drive_req(r, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tot++;
      if (act !== ctrl_t'(0) || rif.req_ready !== 1'b1 || retired !== 32'd0) begin
        bad++;  $display("FAIL reset_state cyc=%0d ctrl=%h ready=%b retired=%h", i, act, rif.req_ready, retired);
      end
    end
    exp_retired = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rif.req_valid = 1'b0;
    e = exp_ctrl(r, 0);
    tot++;
    if (act !== e || act.en_alu !== 1'b1 || act.w !== 1'b1 || act.da !== 5'd3) begin
      bad++;  $display("FAIL first_edge_alu got=%h want=%h", act, e);
    end
    @(posedge clk); #1;
    exp_retired = 32'd1;
    tot++;
    if (rf[3] !== 64'd12 || retired !== exp_retired || rif.req_ready !== 1'b1) begin
      bad++;  $display("FAIL alu_result r3=%0d retired=%0d ready=%b want 12 1 1", rf[3], retired, rif.req_ready);
    end
  endtask

  task automatic test_store_load();
    req_t r;
    rf[0] = 64'h0;  rf[4] = 64'hDEAD;  rf[5] = 64'h0;
    r = rand_req(OP_STORE);  r.rd = 5'd4;  r.rn = 5'd0;  r.imm = 64'd8;
    run_op(r);
    tot++;
    if (ram[8] !== 64'hDEAD) begin
      bad++;  $display("FAIL store_ram got=%h want=dead", ram[8]);
    end
    r = rand_req(OP_LOAD);  r.rd = 5'd5;  r.rn = 5'd0;  r.imm = 64'd8;
    run_op(r);
    tot++;
    if (rf[5] !== 64'hDEAD) begin
      bad++;  $display("FAIL load_r5 got=%h want=dead", rf[5]);
    end
  endtask

  task automatic test_branch();
    req_t r;
    r = rand_req(OP_BR_IMM);  r.imm = 64'h100;
    run_op(r);
    r = rand_req(OP_BR_REG);  r.rn = 5'd2;
    run_op(r);
  endtask

  task automatic test_illegal_wrap();
    req_t r;
    run_op(rand_req(3'd7));
    run_op(rand_req(3'd6));
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.retired_q;
    exp_retired = 32'hFFFF_FFFF;
    r = rand_req(OP_ALU_I);
    run_op(r);
    tot++;
    if (retired !== 32'd0) begin
      bad++;  $display("FAIL retired_wrap got=%h want=0", retired);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(rand_req(3'($urandom_range(0, 7))));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    req_t q [8];
    logic [2:0] ops [5];
    ctrl_t e;
    ops[0] = OP_ALU_R;  ops[1] = OP_ALU_I;  ops[2] = OP_BR_REG;  ops[3] = OP_BR_IMM;  ops[4] = 3'd6;
    for (int i = 0; i < 8; i++) q[i] = rand_req(ops[$urandom_range(0, 4)]);
    @(negedge clk);
    drive_req(q[0], 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      e = exp_ctrl(q[i], 0);
      tot++;
      if (act !== e) begin
        bad++;  $display("FAIL b2b_exec i=%0d got=%h want=%h", i, act, e);
      end
      if (i < 7) drive_req(q[i+1], 1'b1);
      else rif.req_valid = 1'b0;
      @(posedge clk); #1;
      exp_retired = exp_retired + 32'd1;
      tot++;
      if (act !== ctrl_t'(0) || rif.req_ready !== 1'b1 || retired !== exp_retired) begin
        bad++;  $display("FAIL b2b_idle i=%0d ctrl=%h ready=%b retired=%h want retired=%h",
                         i, act, rif.req_ready, retired, exp_retired);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'h0;
    for (int i = 0; i < 256; i++) ram[i] = 64'h0;
    drive_req(rand_req(OP_ALU_R), 1'b0);
    chk_on = 1'b1;
    test_reset_mid_load();
    test_reset();
    test_store_load();
    test_branch();
    test_illegal_wrap();
    test_back_to_back();
    test_random();
    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
